// File: rtl/actmem_banked.sv
// Banked ternary activation memory: write-priority arbitration per bank, starvation-bounded reads.
// Optional macro ACTMEM_OUTPUT_REG_EN adds an output register stage (read latency 1 -> 2).

// Trit code: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1. Byte value (mod 243) holds base-3 digits, trit 0 least significant.
module decoder #(
  parameter int KEEP = 5
) (
  input  logic [7:0]            code_i,
  output logic [KEEP-1:0][1:0]  trits_o
);
  always_comb begin
    logic [7:0] v;
    v = (code_i >= 8'd243) ? code_i - 8'd243 : code_i;
    trits_o = '0;
    for (int k = 0; k < KEEP; k++) begin
      case (v % 8'd3)
        8'd1:    trits_o[k] = 2'b01;
        8'd2:    trits_o[k] = 2'b11;
        default: trits_o[k] = 2'b00;
      endcase
      v = v / 8'd3;
    end
  end
endmodule

// Single-port synchronous SRAM with byte enables; read data appears the cycle after a read request.
module sram_actmem #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int RW    = 4
) (
  input  logic              clk_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [RW-1:0]     addr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   be_i,
  output logic [DW-1:0]     rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int i = 0; i < DW/8; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

module actmem_banked #(
  parameter int N_I            = 512,
  parameter int WEIGHT_STAGGER = 8,
  parameter int NUM_BANKS      = 4,
  parameter int BANKDEPTH      = 1024,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                wr_req_i,
  input  logic [$clog2(NUM_BANKS*BANKDEPTH)-1:0]              wr_addr_i,
  input  logic [((N_I/WEIGHT_STAGGER+4)/5)*8-1:0]             wr_data_i,
  output logic                                                wr_gnt_o,
  input  logic                                                rd_req_i,
  input  logic [$clog2(NUM_BANKS*BANKDEPTH)-1:0]              rd_addr_i,
  output logic                                                rd_gnt_o,
  output logic                                                rd_valid_o,
  output logic [0:N_I/WEIGHT_STAGGER-1][1:0]                  rd_data_o,
  output logic [((N_I/WEIGHT_STAGGER+4)/5)*8-1:0]             rd_data_encoded_o,
  input  logic                                                clear_i,
  output logic [15:0]                                         collision_cnt_o
);
  localparam int ETW    = N_I / WEIGHT_STAGGER;
  localparam int NBYTES = (ETW + 4) / 5;
  localparam int PBW    = NBYTES * 8;
  localparam int LOG2NB = $clog2(NUM_BANKS);
  localparam int BW     = (NUM_BANKS > 1) ? LOG2NB : 1;
  localparam int RW     = $clog2(BANKDEPTH);
  localparam int SW     = $clog2(STARVE_LIMIT + 1);

  logic [BW-1:0]  wr_bank, rd_bank, rd_bank_q;
  logic [RW-1:0]  wr_row, rd_row;
  logic           same_bank, force_rd, rd_gnt, wr_gnt, rd_denied;
  logic [SW-1:0]  starve_q, starve_d;
  logic [15:0]    coll_q, coll_d;
  logic           rd_vld_q;
  logic [PBW-1:0] bank_rdata [NUM_BANKS];
  logic [PBW-1:0] enc;
  logic [ETW-1:0][1:0]   phys;
  logic [0:ETW-1][1:0]   dec_data;

  assign wr_bank = (NUM_BANKS > 1) ? wr_addr_i[BW-1:0] : '0;
  assign rd_bank = (NUM_BANKS > 1) ? rd_addr_i[BW-1:0] : '0;
  assign wr_row  = wr_addr_i[LOG2NB +: RW];
  assign rd_row  = rd_addr_i[LOG2NB +: RW];

  // Writes win a bank conflict unless the read has already waited STARVE_LIMIT cycles.
  assign same_bank = wr_req_i && rd_req_i && (wr_bank == rd_bank);
  assign force_rd  = (starve_q == SW'(STARVE_LIMIT));
  assign rd_gnt    = rd_req_i && (!same_bank || force_rd);
  assign wr_gnt    = wr_req_i && (!same_bank || !force_rd);
  assign rd_denied = rd_req_i && !rd_gnt;
  assign rd_gnt_o  = rd_gnt;
  assign wr_gnt_o  = wr_gnt;

  always_comb begin
    starve_d = starve_q;
    coll_d   = coll_q;
    if (!rd_req_i || rd_gnt) starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    if (clear_i) coll_d = '0;
    else if (rd_denied && coll_q != 16'hFFFF) coll_d = coll_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q  <= '0;
      coll_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      starve_q <= starve_d;
      coll_q   <= coll_d;
      rd_vld_q <= rd_gnt;
      if (rd_gnt) rd_bank_q <= rd_bank;
    end
  end

  assign collision_cnt_o = coll_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel_wr, sel_rd;
    assign sel_wr = wr_gnt && (wr_bank == BW'(b));
    assign sel_rd = rd_gnt && (rd_bank == BW'(b));
    sram_actmem #(.DW(PBW), .DEPTH(BANKDEPTH), .RW(RW)) u_sram (
      .clk_i   (clk_i),
      .req_i   (sel_wr | sel_rd),
      .we_i    (sel_wr),
      .addr_i  (sel_wr ? wr_row : rd_row),
      .wdata_i (wr_data_i),
      .be_i    ('1),
      .rdata_o (bank_rdata[b])
    );
  end

  // Gating here keeps both output buses zero whenever no read is returning.
  assign enc = rd_vld_q ? bank_rdata[rd_bank_q] : '0;

  for (genvar n = 0; n < NBYTES; n++) begin : g_dec
    localparam int KEEP = (n == NBYTES - 1) ? ETW - 5*n : 5;
    logic [KEEP-1:0][1:0] dec_trits;
    decoder #(.KEEP(KEEP)) u_dec (.code_i(enc[8*n +: 8]), .trits_o(dec_trits));
    assign phys[5*n +: KEEP] = dec_trits;
  end

  always_comb begin
    dec_data = '0;
    for (int t = 0; t < ETW; t++) dec_data[t] = phys[ETW-1-t];
  end

`ifdef ACTMEM_OUTPUT_REG_EN
  logic                 out_vld_q;
  logic [0:ETW-1][1:0]  out_dat_q;
  logic [PBW-1:0]       out_enc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_enc_q <= '0;
    end else begin
      out_vld_q <= rd_vld_q;
      out_dat_q <= dec_data;
      out_enc_q <= enc;
    end
  end

  assign rd_valid_o        = out_vld_q;
  assign rd_data_o         = out_dat_q;
  assign rd_data_encoded_o = out_enc_q;
`else
  assign rd_valid_o        = rd_vld_q;
  assign rd_data_o         = dec_data;
  assign rd_data_encoded_o = enc;
`endif
endmodule

// File: tb/tb_actmem_banked.sv
// Directed table-driven bench for actmem_banked plus hand sequences for reset, starvation and saturation.
module tb_actmem_banked;
`ifdef ACTMEM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          wr_req_i, rd_req_i, clear_i;
  logic [11:0]   wr_addr_i, rd_addr_i;
  logic [103:0]  wr_data_i;
  logic          wr_gnt_o, rd_gnt_o, rd_valid_o;
  logic [0:63][1:0] rd_data_o;
  logic [103:0]  rd_data_encoded_o;
  logic [15:0]   collision_cnt_o;

  actmem_banked dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .rd_data_encoded_o(rd_data_encoded_o),
    .clear_i(clear_i), .collision_cnt_o(collision_cnt_o)
  );

  // Small instance with an effectively infinite starve limit, so every conflict cycle counts.
  logic          s_wr, s_rd, s_clr, s_wg, s_rg, s_vld;
  logic [2:0]    s_wa, s_ra;
  logic [7:0]    s_wd, s_enc;
  logic [0:4][1:0] s_dat;
  logic [15:0]   s_coll;

  actmem_banked #(.N_I(40), .WEIGHT_STAGGER(8), .NUM_BANKS(2), .BANKDEPTH(4), .STARVE_LIMIT(1000000)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_req_i(s_wr), .wr_addr_i(s_wa), .wr_data_i(s_wd), .wr_gnt_o(s_wg),
    .rd_req_i(s_rd), .rd_addr_i(s_ra), .rd_gnt_o(s_rg), .rd_valid_o(s_vld),
    .rd_data_o(s_dat), .rd_data_encoded_o(s_enc),
    .clear_i(s_clr), .collision_cnt_o(s_coll)
  );

  typedef struct {
    logic         wr;
    logic [11:0]  wa;
    logic [103:0] wd;
    logic         rd;
    logic [11:0]  ra;
    logic         clr;
    logic         e_wg;
    logic         e_rg;
    logic [15:0]  e_coll;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [103:0] mem [int];
  logic         gv [3];
  logic [103:0] gw [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [11:0] wa, input logic [103:0] wd,
                              input logic rd, input logic [11:0] ra, input logic clr,
                              input logic ewg, input logic erg, input logic [15:0] ec);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra; v.clr = clr;
    v.e_wg = ewg; v.e_rg = erg; v.e_coll = ec;
    return v;
  endfunction

  function automatic logic [103:0] pat(input int k);
    logic [103:0] w;
    for (int b = 0; b < 13; b++) w[8*b +: 8] = 8'((k*53 + b*29 + 7) & 255);
    return w;
  endfunction

  // Reference trit decode by greedy subtraction of powers of three.
  function automatic logic [0:63][1:0] ref_dec(input logic [103:0] w);
    logic [0:63][1:0] r;
    int p, byt, k, v, d, dig, pw;
    for (int t = 0; t < 64; t++) begin
      p = 63 - t; byt = p / 5; k = p % 5;
      v = int'(w[8*byt +: 8]);
      if (v >= 243) v = v - 243;
      pw = 81; dig = 0;
      for (int j = 4; j >= 0; j--) begin
        d = 0;
        while (v >= pw) begin v = v - pw; d++; end
        if (j == k) dig = d;
        pw = pw / 3;
      end
      r[t] = (dig == 0) ? 2'b00 : (dig == 1) ? 2'b01 : 2'b11;
    end
    return r;
  endfunction

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) begin gv[i] = 1'b0; gw[i] = '0; end
  endtask

  task automatic check_out();
    logic e;
    e = gv[LAT-1];
    chk("rd_valid", 128'(rd_valid_o), 128'(e));
    if (e) begin
      chk("rd_enc", 128'(rd_data_encoded_o), 128'(gw[LAT-1]));
      chk("rd_dec", 128'(rd_data_o), 128'(ref_dec(gw[LAT-1])));
    end else begin
      chk("rd_enc_idle", 128'(rd_data_encoded_o), 128'd0);
      chk("rd_dec_idle", 128'(rd_data_o), 128'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [103:0] rw;
    @(negedge clk_i);
    wr_req_i = v.wr; wr_addr_i = v.wa; wr_data_i = v.wd;
    rd_req_i = v.rd; rd_addr_i = v.ra; clear_i = v.clr;
    #1;
    chk("wr_gnt", 128'(wr_gnt_o), 128'(v.e_wg));
    chk("rd_gnt", 128'(rd_gnt_o), 128'(v.e_rg));
    chk("coll", 128'(collision_cnt_o), 128'(v.e_coll));
    check_out();
    rw = mem.exists(int'(v.ra)) ? mem[int'(v.ra)] : '0;
    gv[2] = gv[1]; gw[2] = gw[1];
    gv[1] = gv[0]; gw[1] = gw[0];
    gv[0] = v.rd && v.e_rg; gw[0] = rw;
    if (v.wr && v.e_wg) mem[int'(v.wa)] = v.wd;
  endtask

  task automatic idle_inputs();
    wr_req_i = 0; rd_req_i = 0; clear_i = 0; wr_addr_i = '0; rd_addr_i = '0; wr_data_i = '0;
  endtask

  initial begin
    vec_t tv[$];
    vec_t post[$];
    logic [103:0] ones;
    logic seen;
    ones = '1;

    // 0..16 directed rows, then 16 writes, 16 back-to-back reads across all banks, flush
    tv.push_back(mk(1, 12'd5,  ones,    0, 12'd0,  0, 1, 0, 16'd0));
    tv.push_back(mk(0, 12'd0,  '0,      1, 12'd5,  0, 0, 1, 16'd0));
    tv.push_back(mk(1, 12'd1,  pat(1),  0, 12'd0,  0, 1, 0, 16'd0));
    tv.push_back(mk(1, 12'd12, pat(3),  0, 12'd0,  0, 1, 0, 16'd0));
    tv.push_back(mk(1, 12'd4,  pat(2),  1, 12'd1,  0, 1, 1, 16'd0));
    tv.push_back(mk(1, 12'd8,  pat(4),  1, 12'd12, 0, 1, 0, 16'd0));
    tv.push_back(mk(1, 12'd8,  pat(4),  1, 12'd12, 0, 1, 0, 16'd1));
    tv.push_back(mk(1, 12'd8,  pat(4),  1, 12'd12, 0, 1, 0, 16'd2));
    tv.push_back(mk(1, 12'd8,  pat(4),  1, 12'd12, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 12'd8,  pat(4),  0, 12'd0,  0, 1, 0, 16'd3));
    tv.push_back(mk(1, 12'd8,  pat(4),  1, 12'd12, 1, 1, 0, 16'd3));
    tv.push_back(mk(1, 12'd8,  pat(4),  1, 12'd12, 0, 1, 0, 16'd0));
    tv.push_back(mk(0, 12'd0,  '0,      0, 12'd0,  0, 0, 0, 16'd1));
    tv.push_back(mk(0, 12'd0,  '0,      0, 12'd0,  1, 0, 0, 16'd1));
    tv.push_back(mk(0, 12'd0,  '0,      1, 12'd8,  0, 0, 1, 16'd0));
    tv.push_back(mk(1, 12'd20, pat(5),  0, 12'd0,  0, 1, 0, 16'd0));
    tv.push_back(mk(0, 12'd0,  '0,      1, 12'd20, 0, 0, 1, 16'd0));
    for (int i = 0; i < 16; i++) tv.push_back(mk(1, 12'(32+i), pat(10+i), 0, 12'd0, 0, 1, 0, 16'd0));
    for (int i = 0; i < 16; i++) tv.push_back(mk(0, 12'd0, '0, 1, 12'(32+i), 0, 0, 1, 16'd0));
    for (int i = 0; i < 3; i++)  tv.push_back(mk(0, 12'd0, '0, 0, 12'd0, 0, 0, 0, 16'd0));

    // after a reset mid-collision the starve counter must start over: 3 denials, then forced read
    post.push_back(mk(1, 12'd8, pat(4), 1, 12'd12, 0, 1, 0, 16'd0));
    post.push_back(mk(1, 12'd8, pat(4), 1, 12'd12, 0, 1, 0, 16'd1));
    post.push_back(mk(1, 12'd8, pat(4), 1, 12'd12, 0, 1, 0, 16'd2));
    post.push_back(mk(1, 12'd8, pat(4), 1, 12'd12, 0, 0, 1, 16'd3));
    post.push_back(mk(0, 12'd0, '0,     0, 12'd0,  0, 0, 0, 16'd3));
    post.push_back(mk(0, 12'd0, '0,     0, 12'd0,  0, 0, 0, 16'd3));

    idle_inputs();
    s_wr = 0; s_rd = 0; s_clr = 0; s_wa = '0; s_ra = '0; s_wd = '0;
    clear_pipe();
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", 128'(rd_valid_o), 128'd0);
    chk("rst_coll", 128'(collision_cnt_o), 128'd0);
    chk("rst_enc", 128'(rd_data_encoded_o), 128'd0);
    chk("rst_dec", 128'(rd_data_o), 128'd0);
    chk("rst_gnts", 128'({wr_gnt_o, rd_gnt_o}), 128'd0);
    @(negedge clk_i);
    rst_ni = 1;

    foreach (tv[i]) run_vec(tv[i]);

    // async reset drops a valid read immediately
    @(negedge clk_i);
    idle_inputs(); rd_req_i = 1; rd_addr_i = 12'd5;
    #1 chk("seqA_rd_gnt", 128'(rd_gnt_o), 128'd1);
    @(negedge clk_i);
    rd_req_i = 0;
    repeat (LAT-1) @(negedge clk_i);
    #1;
    chk("seqA_valid", 128'(rd_valid_o), 128'd1);
    chk("seqA_enc", 128'(rd_data_encoded_o), 128'(ones));
    rst_ni = 0;
    #1;
    chk("seqA_valid_rst", 128'(rd_valid_o), 128'd0);
    chk("seqA_enc_rst", 128'(rd_data_encoded_o), 128'd0);
    @(negedge clk_i);
    rst_ni = 1;

    // reset asserted right after a grant: that read must never appear
    @(negedge clk_i);
    rd_req_i = 1; rd_addr_i = 12'd5;
    #1 chk("seqB_rd_gnt", 128'(rd_gnt_o), 128'd1);
    #2 rst_ni = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i == 10) rd_req_i = 0;
      if (i == 21) rst_ni = 1;
      if (rd_valid_o) seen = 1;
    end
    chk("seqB_never_valid", 128'(seen), 128'd0);
    chk("seqB_coll", 128'(collision_cnt_o), 128'd0);

    // build up starve/collision state, then reset before the next edge
    @(negedge clk_i);
    wr_req_i = 1; wr_addr_i = 12'd8; wr_data_i = pat(4); rd_req_i = 1; rd_addr_i = 12'd12;
    @(negedge clk_i);
    @(negedge clk_i);
    #1 chk("seqC_coll_pre", 128'(collision_cnt_o), 128'd2);
    rst_ni = 0;
    #1 chk("seqC_coll_rst", 128'(collision_cnt_o), 128'd0);
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 1;
    clear_pipe();
    foreach (post[i]) run_vec(post[i]);

    // saturation on the unlimited-starve instance
    @(negedge clk_i);
    idle_inputs();
    s_wr = 1; s_wa = 3'd0; s_wd = 8'h5A; s_rd = 1; s_ra = 3'd2;
    repeat (65534) @(negedge clk_i);
    #1 chk("sat_fffe", 128'(s_coll), 128'hFFFE);
    @(negedge clk_i);
    #1 chk("sat_ffff", 128'(s_coll), 128'hFFFF);
    repeat (4464) @(negedge clk_i);
    #1;
    chk("sat_hold", 128'(s_coll), 128'hFFFF);
    chk("sat_rd_denied", 128'({s_rg, s_wg}), 128'b01);
    chk("sat_no_valid", 128'({s_vld, s_enc, s_dat}), 128'd0);
    s_clr = 1;
    @(negedge clk_i);
    s_clr = 0;
    #1 chk("sat_clear", 128'(s_coll), 128'd0);
    @(negedge clk_i);
    #1 chk("sat_restart", 128'(s_coll), 128'd1);
    s_wr = 0; s_rd = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
